bufmem_arbiter: RTL and testbench
=================================

Name: bufmem_arbiter

Overview:
Arbitrates the 1024x8 sector buffer RAM of the floppy subsystem between three requesters: the WD1793 buffer port, the SPI DMA pump and the workhorse 6502. Every access is sequenced as a three-phase transaction (select, drive, ack). A CPU hold output stalls the 6502 while its access is pending. The block sits between the requesters and the single synchronous buffer RAM port, which has 1-cycle read latency.

Parameters:
ADDR_W, 10, buffer address width
MAX_WD_BURST, 4, maximum consecutive WD grants while another requester waits (wd_lock low)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
ce  in  1  clock enable; state advances only when ce=1
wd_req  in  1  WD1793 request; held until wd_ack
wd_we  in  1  WD write (1) / read (0)
wd_addr  in  ADDR_W  WD address
wd_wdata  in  8  WD write data
wd_lock  in  1  reserve buffer for WD only (sector burst)
wd_ack  out  1  one-ce-cycle completion pulse
dma_req, dma_we, dma_addr, dma_wdata, dma_ack  as WD group, DMA requester
cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_ack  as WD group, CPU requester
rdata  out  8  read data; valid in the ack cycle, held until the next ack
cpu_hold  out  1  cpu_req & ~cpu_ack; stall for 6502 enable
mem_cs  out  1  RAM chip select
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  8  RAM write data
mem_rdata  in  8  RAM read data, valid one clk after mem_cs
owner  out  2  current owner: 0 none, 1 WD, 2 DMA, 3 CPU (debug/leds)

Behaviour:
- Reset values: state IDLE, all acks 0, mem_cs 0, mem_we 0, mem_addr 0, mem_wdata 0, rdata 0, owner 0, rr_ptr = DMA, wd_burst 0.
- The FSM has three states: IDLE, DRIVE, DONE. All transitions are qualified by ce. While ce=0, every register holds and acks stay 0.
- IDLE: if any req is present, choose a winner and latch owner, we, addr and wdata from the winner. Go to DRIVE. Otherwise stay in IDLE with owner 0.
- Selection when wd_lock=1: only WD is eligible. DMA and CPU wait, even indefinitely.
- Selection when wd_lock=0, step 1: WD wins if wd_req=1 and either (wd_burst < MAX_WD_BURST) or no other req is present.
- Selection when wd_lock=0, step 2: otherwise DMA and CPU are chosen round-robin. rr_ptr names the preferred requester. If the preferred requester is idle, the other one wins.
- wd_burst: increments on a WD grant (saturating at MAX_WD_BURST). It clears on any DMA or CPU grant, and it clears when there are no requests in IDLE.
- rr_ptr: flips to the other requester after a DMA or CPU grant.
- DRIVE: mem_cs=1, with mem_we, mem_addr and mem_wdata taken from the latched values for exactly one ce cycle. Go to DONE.
- DONE: mem_cs=0 and mem_we=0. Capture rdata <= mem_rdata (reads only; rdata is unchanged on writes). Pulse the owner's ack for this ce cycle. Return to IDLE, where the next grant may be taken on the following ce cycle.
- Latency: grant to ack is 2 ce cycles. Maximum throughput is one access per 3 ce cycles.
- Ack rules: an ack pulse is high only in the DONE cycle and only for the latched owner. No two acks are ever high simultaneously.
- Request withdrawn mid-transaction: the access still completes and the ack still pulses. The requester ignores it. A write is still performed.
- Request fields are sampled only at grant. Changes to addr/wdata after the grant are ignored.
- Simultaneous requests in IDLE are resolved purely by the priority rules above, within the same cycle.
- Address width: mem_addr = latched ADDR_W-bit address, with no offset arithmetic inside the block. The requesters present buffer-relative addresses.
- Reset asserted mid-transaction: on the next clk edge everything returns to reset values. The pending access is dropped without an ack, and no mem_we is issued after reset.

Test Plan:
- Single CPU write then read: cpu write addr 0x155 data 0xA5, then read 0x155 -> mem_we high for 1 ce cycle; cpu_ack 2 ce after each grant; rdata=0xA5; cpu_hold falls in the ack cycle.
- Three simultaneous requests, wd_lock=0, MAX_WD_BURST=4, WD holding req for 10 accesses -> grant order WD,WD,WD,WD,DMA,WD,WD,WD,WD,CPU…; DMA and CPU alternate.
- wd_lock=1 for 8 WD accesses with DMA and CPU requesting -> only wd_ack pulses; after the lock drops, DMA is granted first (rr_ptr reset value), then CPU.
- ce toggling 1-of-3 during a CPU read -> state advances only on ce cycles; ack width is exactly one ce-qualified cycle; rdata is correct.
- Reset asserted in DRIVE of a DMA write to 0x3FF -> next cycle mem_cs=0, dma_ack never pulses, owner=0; a subsequent read of 0x3FF by CPU returns the RAM's prior content.
- CPU drops cpu_req in DRIVE -> cpu_ack still pulses once; the next grant goes to the pending DMA.

Source files
------------

// File: rtl/bufmem_arbiter.sv
// Sector buffer RAM arbiter for the floppy subsystem.
//
// Shares one synchronous 1024x8 buffer RAM port (1-cycle read latency) between
// the WD1793 buffer port, the SPI DMA pump and the 6502. Each access runs as a
// three-phase transaction: IDLE (select winner), DRIVE (RAM strobe), DONE (ack).
//
// Ports:
//   clk, reset, ce                 clock, synchronous active-high reset, clock enable
//   wd_*/dma_*/cpu_*               per-requester req/we/addr/wdata in, ack out
//   wd_lock                        reserve the buffer for WD only
//   rdata                          read data, valid in the ack cycle, held until next ack
//   cpu_hold                       6502 stall while its access is pending
//   mem_cs/mem_we/mem_addr/mem_wdata/mem_rdata   buffer RAM port
//   owner                          0 none, 1 WD, 2 DMA, 3 CPU
module bufmem_arbiter #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned MAX_WD_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,

    input  logic              wd_req,
    input  logic              wd_we,
    input  logic [ADDR_W-1:0] wd_addr,
    input  logic [7:0]        wd_wdata,
    input  logic              wd_lock,
    output logic              wd_ack,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_wdata,
    output logic              dma_ack,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,

    output logic [7:0]        rdata,
    output logic              cpu_hold,

    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,

    output logic [1:0]        owner
);

    localparam int unsigned BurstW = $clog2(MAX_WD_BURST + 1);

    localparam logic [1:0] OwnNone = 2'd0;
    localparam logic [1:0] OwnWd   = 2'd1;
    localparam logic [1:0] OwnDma  = 2'd2;
    localparam logic [1:0] OwnCpu  = 2'd3;

    typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

    state_e              state_q, state_d;
    logic [1:0]          owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [7:0]          rdata_q, rdata_d;
    logic                rr_q, rr_d;        // 0: DMA preferred, 1: CPU preferred
    logic [BurstW-1:0]   burst_q, burst_d;
    logic [1:0]          grant;

    // Winner selection for the current IDLE cycle.
    always_comb begin
        grant = OwnNone;
        if (wd_lock) begin
            if (wd_req) grant = OwnWd;
        end else if (wd_req && ((burst_q < BurstW'(MAX_WD_BURST)) || !(dma_req || cpu_req))) begin
            grant = OwnWd;
        end else if (dma_req && cpu_req) begin
            grant = rr_q ? OwnCpu : OwnDma;
        end else if (dma_req) begin
            grant = OwnDma;
        end else if (cpu_req) begin
            grant = OwnCpu;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rr_d    = rr_q;
        burst_d = burst_q;

        if (ce) begin
            unique case (state_q)
                StIdle: begin
                    unique case (grant)
                        OwnWd: begin
                            we_d    = wd_we;
                            addr_d  = wd_addr;
                            wdata_d = wd_wdata;
                            if (burst_q < BurstW'(MAX_WD_BURST)) burst_d = burst_q + BurstW'(1);
                        end
                        OwnDma: begin
                            we_d    = dma_we;
                            addr_d  = dma_addr;
                            wdata_d = dma_wdata;
                            burst_d = '0;
                            rr_d    = 1'b1;
                        end
                        OwnCpu: begin
                            we_d    = cpu_we;
                            addr_d  = cpu_addr;
                            wdata_d = cpu_wdata;
                            burst_d = '0;
                            rr_d    = 1'b0;
                        end
                        default: begin
                            // Locked-out requesters still count as requests here.
                            if (!(wd_req || dma_req || cpu_req)) burst_d = '0;
                        end
                    endcase
                    if (grant != OwnNone) begin
                        owner_d = grant;
                        state_d = StDrive;
                    end
                end
                StDrive: state_d = StDone;
                StDone: begin
                    if (!we_q) rdata_d = mem_rdata;
                    owner_d = OwnNone;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= OwnNone;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rr_q    <= 1'b0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
        end
    end

    logic done_ce;
    assign done_ce = (state_q == StDone) && ce;

    // Strobe gated by reset so a reset landing in DRIVE cannot commit a write.
    assign mem_cs    = (state_q == StDrive) && !reset;
    assign mem_we    = mem_cs && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign wd_ack  = done_ce && (owner_q == OwnWd);
    assign dma_ack = done_ce && (owner_q == OwnDma);
    assign cpu_ack = done_ce && (owner_q == OwnCpu);

    // Pass RAM data straight through during DONE so it is valid alongside the ack.
    assign rdata    = ((state_q == StDone) && !we_q) ? mem_rdata : rdata_q;
    assign cpu_hold = cpu_req && !cpu_ack;
    assign owner    = owner_q;

endmodule

// File: tb/tb_bufmem_arbiter.sv
// Scoreboard bench for bufmem_arbiter: stimulus pushes expected acks (owner and,
// for reads, data) into a queue; a negedge monitor pops and checks each ack.
module tb_bufmem_arbiter;

    logic       clk, reset, ce;
    logic       wd_req, wd_we, wd_lock, wd_ack;
    logic [9:0] wd_addr;
    logic [7:0] wd_wdata;
    logic       dma_req, dma_we, dma_ack;
    logic [9:0] dma_addr;
    logic [7:0] dma_wdata;
    logic       cpu_req, cpu_we, cpu_ack;
    logic [9:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic [7:0] rdata;
    logic       cpu_hold;
    logic       mem_cs, mem_we;
    logic [9:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic [1:0] owner;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [1:0] who;
        logic       chk;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    bufmem_arbiter #(.ADDR_W(10), .MAX_WD_BURST(4)) dut (
        .clk(clk), .reset(reset), .ce(ce),
        .wd_req(wd_req), .wd_we(wd_we), .wd_addr(wd_addr), .wd_wdata(wd_wdata),
        .wd_lock(wd_lock), .wd_ack(wd_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack),
        .rdata(rdata), .cpu_hold(cpu_hold),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer RAM model; initial contents are ram[a] = a*3+7 (mod 256).
    logic [7:0] ram [1024];
    logic       ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 8'(i * 3 + 7);
            ram_ready <= 1'b1;
        end else if (mem_cs) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [1:0] who, input logic chk, input logic [7:0] data);
        exp_t e;
        e.who = who; e.chk = chk; e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every ack must match the next scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        logic [1:0] who;
        if (wd_ack || dma_ack || cpu_ack) begin
            check("ack_onehot", $countones({wd_ack, dma_ack, cpu_ack}), 1);
            who = wd_ack ? 2'd1 : (dma_ack ? 2'd2 : 2'd3);
            if (exp_q.size() == 0) begin
                check("unexpected_ack", {30'd0, who}, 0);
            end else begin
                e = exp_q.pop_front();
                check("ack_owner", {30'd0, who}, {30'd0, e.who});
                if (e.chk) check("ack_rdata", {24'd0, rdata}, {24'd0, e.data});
            end
        end
    end

    task automatic set_req(input logic [1:0] who, input logic req, input logic we,
                           input logic [9:0] addr, input logic [7:0] wd);
        case (who)
            2'd1: begin wd_req = req; wd_we = we; wd_addr = addr; wd_wdata = wd; end
            2'd2: begin dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wd; end
            default: begin cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
        endcase
    endtask

    task automatic wait_ack(input logic [1:0] who, input int budget, output int n);
        logic got;
        got = 1'b0;
        n = 0;
        while (!got && n < budget) begin
            @(posedge clk); #1;
            n++;
            got = (who == 2'd1) ? wd_ack : ((who == 2'd2) ? dma_ack : cpu_ack);
        end
        check("ack_timeout", {31'd0, got}, 1);
    endtask

    // Hold requests until each requester has seen its quota of acks.
    task automatic run_multi(input int nw, input int nd, input int nc, input int budget);
        int cw, cd, cc, n;
        cw = 0; cd = 0; cc = 0; n = 0;
        while ((cw < nw || cd < nd || cc < nc) && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (wd_ack)  begin cw++; if (cw >= nw) begin wd_req = 1'b0; wd_lock = 1'b0; end end
            if (dma_ack) begin cd++; if (cd >= nd) dma_req = 1'b0; end
            if (cpu_ack) begin cc++; if (cc >= nc) cpu_req = 1'b0; end
        end
        check("multi_wd_count", cw, nw);
        check("multi_dma_count", cd, nd);
        check("multi_cpu_count", cc, nc);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        int n, ncs, nce, nack, ack_nce;
        reset = 1'b1; ce = 1'b1; wd_lock = 1'b0;
        set_req(2'd1, 1'b0, 1'b0, 10'd0, 8'd0);
        set_req(2'd2, 1'b0, 1'b0, 10'd0, 8'd0);
        set_req(2'd3, 1'b0, 1'b0, 10'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_owner", {30'd0, owner}, 0);
        check("rst_mem_cs_we", {30'd0, mem_cs, mem_we}, 0);
        check("rst_mem_addr", {22'd0, mem_addr}, 0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 0);
        check("rst_rdata", {24'd0, rdata}, 0);
        check("rst_acks", {29'd0, wd_ack, dma_ack, cpu_ack}, 0);
        reset = 1'b0;

        // CPU write 0x155 <= 0xA5, then read it back.
        @(posedge clk); #1;
        set_req(2'd3, 1'b1, 1'b1, 10'h155, 8'hA5);
        push_exp(2'd3, 1'b0, 8'h00);
        @(posedge clk); #1;
        check("w_drive_cs_we", {30'd0, mem_cs, mem_we}, 32'b11);
        check("w_drive_addr", {22'd0, mem_addr}, 32'h155);
        check("w_drive_wdata", {24'd0, mem_wdata}, 32'hA5);
        check("w_drive_owner", {30'd0, owner}, 3);
        check("w_drive_hold", {31'd0, cpu_hold}, 1);
        @(posedge clk); #1;
        check("w_done_ack", {31'd0, cpu_ack}, 1);
        check("w_done_cs_we", {30'd0, mem_cs, mem_we}, 0);
        check("w_done_hold", {31'd0, cpu_hold}, 0);
        set_req(2'd3, 1'b1, 1'b0, 10'h155, 8'h00);
        push_exp(2'd3, 1'b1, 8'hA5);
        wait_ack(2'd3, 10, n);
        check("r_latency", n, 3);
        set_req(2'd3, 1'b0, 1'b0, 10'h155, 8'h00);
        @(posedge clk); #1;
        check("r_rdata_held", {24'd0, rdata}, 32'hA5);

        // Three-way contention with WD burst limit.
        do_reset();
        set_req(2'd1, 1'b1, 1'b1, 10'h100, 8'h11);
        set_req(2'd2, 1'b1, 1'b1, 10'h180, 8'h22);
        set_req(2'd3, 1'b1, 1'b1, 10'h1C0, 8'h33);
        for (int i = 0; i < 4; i++) push_exp(2'd1, 1'b0, 8'h00);
        push_exp(2'd2, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) push_exp(2'd1, 1'b0, 8'h00);
        push_exp(2'd3, 1'b0, 8'h00);
        push_exp(2'd1, 1'b0, 8'h00);
        push_exp(2'd1, 1'b0, 8'h00);
        push_exp(2'd2, 1'b0, 8'h00);
        push_exp(2'd3, 1'b0, 8'h00);
        run_multi(10, 2, 2, 200);

        // wd_lock excludes DMA and CPU; afterwards DMA first, then CPU.
        do_reset();
        wd_lock = 1'b1;
        set_req(2'd1, 1'b1, 1'b1, 10'h140, 8'h44);
        set_req(2'd2, 1'b1, 1'b0, 10'h010, 8'h00);
        set_req(2'd3, 1'b1, 1'b0, 10'h020, 8'h00);
        for (int i = 0; i < 8; i++) push_exp(2'd1, 1'b0, 8'h00);
        push_exp(2'd2, 1'b1, 8'h37);
        push_exp(2'd3, 1'b1, 8'h67);
        run_multi(8, 1, 1, 200);

        // CPU read with ce active one cycle in three.
        do_reset();
        push_exp(2'd3, 1'b1, 8'hA5);
        ncs = 0; nce = 0; nack = 0; ack_nce = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk); #1;
            ce = (cyc % 3 == 0);
            if (cyc == 0) set_req(2'd3, 1'b1, 1'b0, 10'h155, 8'h00);
            #1;
            if (mem_cs) ncs++;
            if (ce) nce++;
            if (cpu_ack) begin
                nack++;
                ack_nce = nce;
                cpu_req = 1'b0;
            end
        end
        ce = 1'b1;
        check("ce_ack_count", nack, 1);
        check("ce_ack_nce", ack_nce, 3);
        check("ce_cs_cycles", ncs, 3);

        // Reset landing in DRIVE of a DMA write to 0x3FF.
        do_reset();
        set_req(2'd2, 1'b1, 1'b1, 10'h3FF, 8'hEE);
        @(posedge clk); #1;
        check("rst_mid_cs", {31'd0, mem_cs}, 1);
        check("rst_mid_owner", {30'd0, owner}, 2);
        reset = 1'b1;
        dma_req = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_cs_after", {31'd0, mem_cs}, 0);
        check("rst_mid_owner_after", {30'd0, owner}, 0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        set_req(2'd3, 1'b1, 1'b0, 10'h3FF, 8'h00);
        push_exp(2'd3, 1'b1, 8'h04);
        wait_ack(2'd3, 10, n);
        cpu_req = 1'b0;

        // CPU withdraws in DRIVE; its write still lands and DMA goes next.
        do_reset();
        set_req(2'd3, 1'b1, 1'b1, 10'h200, 8'h5A);
        push_exp(2'd3, 1'b0, 8'h00);
        @(posedge clk); #1;
        check("wd_drive_owner", {30'd0, owner}, 3);
        cpu_req = 1'b0;
        set_req(2'd2, 1'b1, 1'b0, 10'h200, 8'h00);
        push_exp(2'd2, 1'b1, 8'h5A);
        @(posedge clk); #1;
        check("wd_cpu_ack", {31'd0, cpu_ack}, 1);
        wait_ack(2'd2, 10, n);
        check("wd_dma_latency", n, 3);
        dma_req = 1'b0;

        repeat (5) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
